// File: rtl/pipeline_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_unit
//
// Operand bypass and hazard detection for an in-order core. Every instruction
// past decode is tracked in a DEPTH-entry scoreboard that shifts along with
// the pipeline. Decode-stage source operands are resolved from the youngest
// in-flight producer of the same register. If that producer's result is not
// yet present in stageData, a stall is raised.
//
// Ports
//   clock, reset      core clock, synchronous active-low reset
//   idValid..idIsLoad decode-stage instruction description
//   rfData1/2         register-file read data for rs1/rs2
//   stageData         result of tracked stage k at [k*XLEN +: XLEN]
//   flush             kill the decode instruction
//   hold              freeze the tracked pipeline
//   operand1/2        resolved source operand values
//   fwdSel1/2         0 = register file, k+1 = bypass from stage k
//   stall             decode must hold, PC must not advance
//   issue             decode instruction enters stage 0 this cycle
//   stallCount        saturating count of non-hold stall cycles
// ---------------------------------------------------------------------------
module pipeline_hazard_unit #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 3,
    parameter int REGBITS    = 5,
    parameter int ALU_READY  = 1,
    parameter int LOAD_READY = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    idValid,
    input  logic [REGBITS-1:0]      idRs1,
    input  logic [REGBITS-1:0]      idRs2,
    input  logic                    idUse1,
    input  logic                    idUse2,
    input  logic [REGBITS-1:0]      idRd,
    input  logic                    idRegWrite,
    input  logic                    idIsLoad,
    input  logic [XLEN-1:0]         rfData1,
    input  logic [XLEN-1:0]         rfData2,
    input  logic [DEPTH*XLEN-1:0]   stageData,
    input  logic                    flush,
    input  logic                    hold,
    output logic [XLEN-1:0]         operand1,
    output logic [XLEN-1:0]         operand2,
    output logic [REGBITS-1:0]      fwdSel1,
    output logic [REGBITS-1:0]      fwdSel2,
    output logic                    stall,
    output logic                    issue,
    output logic [31:0]             stallCount
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Scoreboard: valid, destination, writes-rd, result-comes-from-memory
    logic [DEPTH-1:0]              v_q, v_d;
    logic [DEPTH-1:0][REGBITS-1:0] rd_q, rd_d;
    logic [DEPTH-1:0]              wr_q, wr_d;
    logic [DEPTH-1:0]              ld_q, ld_d;
    logic [31:0]                   stall_cnt_q, stall_cnt_d;

    logic [DEPTH-1:0] match1_s, match2_s, ready_s;
    logic [IDXW-1:0]  prod1_s, prod2_s;
    logic             hit1_s, hit2_s, fwd1_s, fwd2_s, pend1_s, pend2_s;

    // Index of the lowest set bit, i.e. the youngest matching producer.
    function automatic logic [IDXW-1:0] youngest(input logic [DEPTH-1:0] m);
        logic [IDXW-1:0] idx;
        idx = {IDXW{1'b0}};
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (m[k]) begin
                idx = IDXW'(k);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Per-stage match vectors and result-ready flags.
    always_comb begin
        match1_s = {DEPTH{1'b0}};
        match2_s = {DEPTH{1'b0}};
        ready_s  = {DEPTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            // x0 is hard-wired zero and never produced by the pipeline
            match1_s[k] = v_q[k] & wr_q[k] & (rd_q[k] == idRs1) &
                          (idRs1 != {REGBITS{1'b0}}) & idUse1;
            match2_s[k] = v_q[k] & wr_q[k] & (rd_q[k] == idRs2) &
                          (idRs2 != {REGBITS{1'b0}}) & idUse2;
            ready_s[k]  = ld_q[k] ? (k >= LOAD_READY) : (k >= ALU_READY);
        end
    end

    assign hit1_s  = |match1_s;
    assign hit2_s  = |match2_s;
    assign prod1_s = youngest(match1_s);
    assign prod2_s = youngest(match2_s);
    assign fwd1_s  = hit1_s & ready_s[prod1_s];
    assign fwd2_s  = hit2_s & ready_s[prod2_s];
    assign pend1_s = hit1_s & ~ready_s[prod1_s];
    assign pend2_s = hit2_s & ~ready_s[prod2_s];

    // Operand selection; a pending producer leaves the register-file value
    // on the operand since decode is stalled anyway.
    always_comb begin
        if (fwd1_s) begin
            operand1 = stageData[int'(prod1_s)*XLEN +: XLEN];
            fwdSel1  = REGBITS'(prod1_s) + REGBITS'(1);
        end else begin
            operand1 = rfData1;
            fwdSel1  = {REGBITS{1'b0}};
        end
        if (fwd2_s) begin
            operand2 = stageData[int'(prod2_s)*XLEN +: XLEN];
            fwdSel2  = REGBITS'(prod2_s) + REGBITS'(1);
        end else begin
            operand2 = rfData2;
            fwdSel2  = {REGBITS{1'b0}};
        end
    end

    // flush kills the decode instruction, so it can neither stall nor issue.
    assign stall      = idValid & ~flush & (pend1_s | pend2_s);
    assign issue      = idValid & ~stall & ~flush & ~hold;
    assign stallCount = stall_cnt_q;

    // Next scoreboard state: shift one stage unless frozen by hold.
    always_comb begin
        v_d         = v_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        ld_d        = ld_q;
        stall_cnt_d = stall_cnt_q;
        if (!hold) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                v_d[k]  = v_q[k-1];
                rd_d[k] = rd_q[k-1];
                wr_d[k] = wr_q[k-1];
                ld_d[k] = ld_q[k-1];
            end
            v_d[0]  = issue;
            rd_d[0] = idRd;
            wr_d[0] = idRegWrite;
            ld_d[0] = idIsLoad;
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Scoreboard and stall counter registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            v_q         <= {DEPTH{1'b0}};
            rd_q        <= '0;
            wr_q        <= {DEPTH{1'b0}};
            ld_q        <= {DEPTH{1'b0}};
            stall_cnt_q <= 32'd0;
        end else begin
            v_q         <= v_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            ld_q        <= ld_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
